// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem req/gnt/rvalid fetch, decode valid/ready hand-off.
// Optional performance counters are compiled in when IF_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_offset,
  input  logic        redirect_is_jalr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4,
    TRAP  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instruction_q, instruction_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_misaligned_q, fetch_misaligned_d;
  logic [XLEN-1:0]   target;
  logic              outstanding;
  logic              handshake;

  assign imem_req         = (state_q == REQ);
  assign imem_addr        = pc_q;
  assign instr_valid      = instr_valid_q;
  assign instruction      = instruction_q;
  assign instr_pc         = instr_pc_q;
  assign fetch_misaligned = fetch_misaligned_q;

  // Next-state and datapath; a redirect overrides whatever the state decided.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    instruction_d      = instruction_q;
    instr_pc_d         = instr_pc_q;
    instr_valid_d      = instr_valid_q;
    fetch_misaligned_d = fetch_misaligned_q;

    target = redirect_base + redirect_offset;
    if (redirect_is_jalr) begin
      target[0] = 1'b0;
    end
    handshake   = (state_q == HOLD) && instr_valid_q && instr_ready;
    outstanding = ((state_q == REQ) && imem_gnt) ||
                  (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid);

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instruction_d = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + XLEN'(4);
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          instr_valid_d = 1'b0;
          instruction_d = NOP_INSTR;
          state_d       = REQ;
        end
      end
      DRAIN: begin
        // Pending misalignment is remembered by the exception flag itself
        if (imem_rvalid) begin
          state_d = fetch_misaligned_q ? TRAP : REQ;
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      instr_valid_d      = 1'b0;
      instruction_d      = NOP_INSTR;
      pc_d               = target;
      fetch_misaligned_d = (target[1:0] != 2'b00);
      if (outstanding) begin
        state_d = DRAIN;
      end else if (target[1:0] != 2'b00) begin
        state_d = TRAP;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      pc_q               <= RESET_PC;
      instruction_q      <= NOP_INSTR;
      instr_pc_q         <= '0;
      instr_valid_q      <= 1'b0;
      fetch_misaligned_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      instruction_q      <= instruction_d;
      instr_pc_q         <= instr_pc_d;
      instr_valid_q      <= instr_valid_d;
      fetch_misaligned_q <= fetch_misaligned_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [XLEN-1:0] perf_stall_cnt_q, perf_stall_cnt_d;

  // Stalls: waiting for grant, or waiting for read data (live or drained)
  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (handshake) begin
      perf_fetch_cnt_d = perf_fetch_cnt_q + XLEN'(1);
    end
    if (((state_q == REQ) && !imem_gnt) ||
        (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid)) begin
      perf_stall_cnt_d = perf_stall_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit; inputs driven and outputs checked on the falling edge.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_base;
  logic [31:0] redirect_offset;
  logic        redirect_is_jalr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_base    (redirect_base),
    .redirect_offset  (redirect_offset),
    .redirect_is_jalr (redirect_is_jalr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instruction      (instruction),
    .instr_pc         (instr_pc),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_stall_cnt   (perf_stall_cnt),
`endif
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        rdir;
    logic [31:0] base;
    logic [31:0] off;
    logic        jalr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl [19];

  function automatic vec_t mkv(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                               input logic rdir, input logic [31:0] b, input logic [31:0] o, input logic j,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ei, input logic [31:0] ep, input logic em);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
    v.rdir = rdir; v.base = b; v.off = o; v.jalr = j;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".imem_req"},    32'(imem_req),         32'(v.e_req));
    chk({tag, ".imem_addr"},   imem_addr,             v.e_addr);
    chk({tag, ".instr_valid"}, 32'(instr_valid),      32'(v.e_valid));
    chk({tag, ".instruction"}, instruction,           v.e_instr);
    chk({tag, ".instr_pc"},    instr_pc,              v.e_pc);
    chk({tag, ".misaligned"},  32'(fetch_misaligned), 32'(v.e_mis));
  endtask

  task automatic drive(input vec_t v);
    imem_gnt         = v.gnt;
    imem_rvalid      = v.rvalid;
    imem_rdata       = v.rdata;
    instr_ready      = v.ready;
    redirect_valid   = v.rdir;
    redirect_base    = v.base;
    redirect_offset  = v.off;
    redirect_is_jalr = v.jalr;
  endtask

  // One cycle: at the falling edge check outputs, then drive inputs for the next rising edge
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    chk_outs(tag, v);
    drive(v);
  endtask

  // Full fetch starting in REQ: gdly grant-less cycles, grant, data next cycle, accepted in HOLD
  task automatic fetch_one(input int gdly, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] prev_pc, input string tag);
    for (int k = 0; k < gdly; k++)
      apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, addr, 0, NOP, prev_pc, 0), {tag, ".req_wait"});
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, addr, 0, NOP, prev_pc, 0), {tag, ".req_gnt"});
    apply(mkv(0, 1, data, 0, 0, 0, 0, 0, 0, addr, 0, NOP, prev_pc, 0), {tag, ".wait"});
    apply(mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, addr + 32'd4, 1, data, addr, 0), {tag, ".hold"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    z = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0);

    // Zero-wait stream, 5-cycle decode stall, then redirect while WAIT with slow read data
    tbl[0]  = mkv(1, 0, 0,             0, 0, 0,      0,     0, 1, 32'h0,   0, NOP,           32'h0, 0);
    tbl[1]  = mkv(0, 1, 32'h1111_0001, 0, 0, 0,      0,     0, 0, 32'h0,   0, NOP,           32'h0, 0);
    tbl[2]  = mkv(0, 0, 0,             1, 0, 0,      0,     0, 0, 32'h4,   1, 32'h1111_0001, 32'h0, 0);
    tbl[3]  = mkv(1, 0, 0,             1, 0, 0,      0,     0, 1, 32'h4,   0, NOP,           32'h0, 0);
    tbl[4]  = mkv(0, 1, 32'h1111_0002, 1, 0, 0,      0,     0, 0, 32'h4,   0, NOP,           32'h0, 0);
    tbl[5]  = mkv(0, 0, 0,             1, 0, 0,      0,     0, 0, 32'h8,   1, 32'h1111_0002, 32'h4, 0);
    tbl[6]  = mkv(1, 0, 0,             0, 0, 0,      0,     0, 1, 32'h8,   0, NOP,           32'h4, 0);
    tbl[7]  = mkv(0, 1, 32'h1111_0003, 0, 0, 0,      0,     0, 0, 32'h8,   0, NOP,           32'h4, 0);
    for (int i = 8; i <= 12; i++)
      tbl[i] = mkv(0, 0, 0,            0, 0, 0,      0,     0, 0, 32'hC,   1, 32'h1111_0003, 32'h8, 0);
    tbl[13] = mkv(0, 0, 0,             1, 0, 0,      0,     0, 0, 32'hC,   1, 32'h1111_0003, 32'h8, 0);
    tbl[14] = mkv(1, 0, 0,             0, 0, 0,      0,     0, 1, 32'hC,   0, NOP,           32'h8, 0);
    tbl[15] = mkv(0, 0, 0,             0, 1, 32'h100, 32'h20, 0, 0, 32'hC, 0, NOP,           32'h8, 0);
    tbl[16] = mkv(0, 0, 0,             0, 0, 0,      0,     0, 0, 32'h120, 0, NOP,           32'h8, 0);
    tbl[17] = mkv(0, 1, 32'hDEAD_BEEF, 0, 0, 0,      0,     0, 0, 32'h120, 0, NOP,           32'h8, 0);
    tbl[18] = mkv(0, 0, 0,             0, 0, 0,      0,     0, 1, 32'h120, 0, NOP,           32'h8, 0);

    rst_n = 1'b0;
    drive(z);
    repeat (2) @(negedge clk);
    chk_outs("reset", z);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++)
      apply(tbl[i], $sformatf("tbl%0d", i));

    // JALR clears bit 0; misaligned branch traps; misaligned redirect in TRAP stays; aligned one recovers
    apply(mkv(0, 0, 0, 0, 1, 32'h201, 0, 1, 1, 32'h120, 0, NOP, 32'h8, 0), "jalr.req");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0, NOP, 32'h8, 0), "jalr.idle");
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, NOP, 32'h8, 0), "jalr.reqgnt");
    apply(mkv(0, 1, 32'h2222_0001, 0, 0, 0, 0, 0, 0, 32'h200, 0, NOP, 32'h8, 0), "jalr.wait");
    apply(mkv(0, 0, 0, 1, 1, 32'h200, 32'h2, 0, 0, 32'h204, 1, 32'h2222_0001, 32'h200, 0), "mis.hold");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h202, 0, NOP, 32'h200, 1), "mis.trap0");
    apply(mkv(0, 0, 0, 0, 1, 32'h204, 32'h2, 0, 0, 32'h202, 0, NOP, 32'h200, 1), "mis.trap1");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h206, 0, NOP, 32'h200, 1), "mis.trap2");
    apply(mkv(0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 32'h206, 0, NOP, 32'h200, 1), "mis.trap3");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300, 0, NOP, 32'h200, 0), "mis.idle");
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, NOP, 32'h200, 0), "mis.req");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300, 0, NOP, 32'h200, 0), "rst.wait0");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300, 0, NOP, 32'h200, 0), "rst.wait1");

    // Asynchronous reset in the middle of WAIT, checked before any clock edge
    #2 rst_n = 1'b0;
    #1 chk_outs("rst.async", z);
    @(negedge clk);
    rst_n = 1'b1;

    // Address wrap from 0xFFFF_FFFC to 0
    apply(mkv(0, 0, 0, 0, 1, 32'hFFFF_FFF0, 32'hC, 0, 1, 32'h0, 0, NOP, 32'h0, 0), "wrap.req");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, NOP, 32'h0, 0), "wrap.idle");
    fetch_one(0, 32'hFFFF_FFFC, 32'h3333_0001, 32'h0, "wrap");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, NOP, 32'hFFFF_FFFC, 0), "wrap.next");

    // Three fetches with grant delayed two cycles each
    @(negedge clk);
    drive(z);
    rst_n = 1'b0;
    @(negedge clk);
`ifdef IF_PERF_CNT_EN
    chk("perf.fetch_rst", perf_fetch_cnt, 32'd0);
    chk("perf.stall_rst", perf_stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    fetch_one(2, 32'h0, 32'h4444_0001, 32'h0, "slow0");
    fetch_one(2, 32'h4, 32'h4444_0002, 32'h0, "slow1");
    fetch_one(2, 32'h8, 32'h4444_0003, 32'h4, "slow2");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC, 0, NOP, 32'h8, 0), "slow.end");
`ifdef IF_PERF_CNT_EN
    chk("perf.fetch_cnt", perf_fetch_cnt, 32'd3);
    chk("perf.stall_cnt", perf_stall_cnt, 32'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
